// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pairs queued BHT predictions with resolved ID outcomes,
// drives the predictor update port and a registered redirect on mispredict.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  input  logic [`WORD_LEN-1:0] push_pc,
  input  logic                 push_pred_taken,
  input  logic [`WORD_LEN-1:0] push_pred_target,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  input  logic [`WORD_LEN-1:0] resolve_target,
  input  logic                 flush,
  output logic                 full,
  output logic [PTR_BITS:0]    count,
  output logic                 update_en,
  output logic [`WORD_LEN-1:0] update_pc,
  output logic                 update_taken,
  output logic                 mispredict,
  output logic [`WORD_LEN-1:0] redirect_pc,
  output logic                 overflow_err,
  output logic                 underflow_err
);
  localparam int W = `WORD_LEN;
  localparam int CW = PTR_BITS + 1;
  logic [W-1:0]        pc_q [DEPTH];
  logic                pt_q [DEPTH];
  logic [W-1:0]        tg_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                update_en_q, update_en_d, update_taken_q, update_taken_d;
  logic                mispredict_q, mispredict_d, overflow_err_q, overflow_err_d;
  logic                underflow_err_q, underflow_err_d;
  logic [W-1:0]        update_pc_q, update_pc_d, redirect_pc_q, redirect_pc_d;
  logic                empty, pop, mis, we, discard;
  logic [W-1:0]        head_pc, head_tg;
  logic                head_pt;
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    head_pc = pc_q[rd_ptr_q];
    head_pt = pt_q[rd_ptr_q];
    head_tg = tg_q[rd_ptr_q];
    pop = resolve_valid && !empty && !flush;
    mis = pop && (head_pt != resolve_taken || (head_pt && resolve_taken && head_tg != resolve_target));
    discard = flush || mis;
    // a correct pop in the same cycle frees the slot a full-queue push needs
    we = push_valid && !discard && (!full || pop);
    wr_ptr_d = discard ? '0 : wr_ptr_q + PTR_BITS'(we);
    rd_ptr_d = discard ? '0 : rd_ptr_q + PTR_BITS'(pop);
    count_d = discard ? '0 : count_q + CW'(we) - CW'(pop);
    update_en_d = pop;
    update_pc_d = pop ? head_pc : update_pc_q;
    update_taken_d = pop ? resolve_taken : update_taken_q;
    mispredict_d = mis;
    redirect_pc_d = mis ? (resolve_taken ? resolve_target : head_pc + W'(4)) : redirect_pc_q;
    overflow_err_d = overflow_err_q || (push_valid && !flush && full && !pop);
    underflow_err_d = underflow_err_q || (resolve_valid && !flush && empty);
  end
  always_ff @(posedge clk)
    if (we) begin
      pc_q[wr_ptr_q] <= push_pc;
      pt_q[wr_ptr_q] <= push_pred_taken;
      tg_q[wr_ptr_q] <= push_pred_target;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      update_en_q <= 1'b0;
      update_pc_q <= '0;
      update_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_pc_q <= '0;
      overflow_err_q <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      update_en_q <= update_en_d;
      update_pc_q <= update_pc_d;
      update_taken_q <= update_taken_d;
      mispredict_q <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      overflow_err_q <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  assign count = count_q;
  assign update_en = update_en_q;
  assign update_pc = update_pc_q;
  assign update_taken = update_taken_q;
  assign mispredict = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign overflow_err = overflow_err_q;
  assign underflow_err = underflow_err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed plan plus random traffic against a queue-based reference model.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tg;
  } ent_t;
  logic        clk = 0, rst = 1;
  logic        push_valid = 0, push_pred_taken = 0, resolve_valid = 0, resolve_taken = 0, flush = 0;
  logic [31:0] push_pc = 0, push_pred_target = 0, resolve_target = 0;
  logic        full, update_en, update_taken, mispredict, overflow_err, underflow_err;
  logic [2:0]  count;
  logic [31:0] update_pc, redirect_pc;
  int          errors = 0, checks = 0;
  ent_t        q[$];
  logic        e_uen, e_ut, e_mis, e_ovf, e_unf;
  logic [31:0] e_upc, e_rpc;
  branch_resolve_unit #(.DEPTH(DEPTH), .PTR_BITS(2)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_pc(push_pc),
    .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .flush(flush), .full(full), .count(count), .update_en(update_en), .update_pc(update_pc),
    .update_taken(update_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    {e_uen, e_ut, e_mis, e_ovf, e_unf} = '0;
    e_upc = 0;
    e_rpc = 0;
  endtask
  task automatic model_step();
    int n;
    logic m;
    ent_t h;
    n = q.size();
    m = 0;
    e_uen = resolve_valid && n != 0 && !flush;
    e_mis = 0;
    if (e_uen) begin
      h = q[0];
      e_upc = h.pc;
      e_ut = resolve_taken;
      m = (h.pt != resolve_taken) || (h.pt && resolve_taken && h.tg != resolve_target);
      if (m) begin
        e_mis = 1;
        e_rpc = resolve_taken ? resolve_target : h.pc + 32'd4;
      end
    end
    if (resolve_valid && n == 0 && !flush) e_unf = 1;
    if (flush || m) q.delete();
    else begin
      if (e_uen) void'(q.pop_front());
      if (push_valid) begin
        if (q.size() < DEPTH) q.push_back('{push_pc, push_pred_taken, push_pred_target});
        else e_ovf = 1;
      end
    end
  endtask
  task automatic check_all();
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("update_en", 64'(update_en), 64'(e_uen));
    chk("update_pc", 64'(update_pc), 64'(e_upc));
    chk("update_taken", 64'(update_taken), 64'(e_ut));
    chk("mispredict", 64'(mispredict), 64'(e_mis));
    chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
    chk("overflow_err", 64'(overflow_err), 64'(e_ovf));
    chk("underflow_err", 64'(underflow_err), 64'(e_unf));
  endtask
  task automatic drive(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] tg,
                       input logic rv, input logic rt, input logic [31:0] rtg, input logic fl);
    push_valid = pv; push_pc = pc; push_pred_taken = pt; push_pred_target = tg;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg; flush = fl;
  endtask
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    #1 check_all();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #3 rst = 0;
  endtask
  initial begin
    model_reset();
    do_reset();
    // plan 1
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk("p1_update_pc", 64'(update_pc), 64'h10);
    cyc();
    // plan 2
    drive(1, 32'h20, 1, 32'h40, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 1, 1, 32'h44, 0); cyc();
    chk("p2_redirect", 64'(redirect_pc), 64'h44);
    cyc();
    // plan 3
    drive(1, 32'h30, 1, 32'h80, 0, 0, 0, 0); cyc();
    drive(1, 32'h34, 0, 0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk("p3_redirect", 64'(redirect_pc), 64'h34);
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk("p3_underflow", 64'(underflow_err), 64'(1));
    // plan 4
    for (int i = 0; i < 4; i++) begin drive(1, 32'h100 + 32'(i * 4), 0, 0, 0, 0, 0, 0); cyc(); end
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0); cyc();
    chk("p4_overflow", 64'(overflow_err), 64'(1));
    drive(1, 32'h110, 0, 0, 1, 0, 0, 0); cyc();
    chk("p4_count", 64'(count), 64'(4));
    for (int i = 0; i < 6; i++) begin drive(0, 0, 0, 0, 1, 0, 0, 0); cyc(); end
    // plan 5
    for (int i = 0; i < 3; i++) begin drive(1, 32'h300 + 32'(i * 4), 1, 32'h500, 0, 0, 0, 0); cyc(); end
    drive(0, 0, 0, 0, 1, 0, 0, 1); cyc();
    chk("p5_count", 64'(count), 64'(0));
    // plan 6: count=2 with update_en high, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin drive(1, 32'h400 + 32'(i * 4), 0, 0, 0, 0, 0, 0); cyc(); end
    drive(0, 0, 0, 0, 1, 0, 0, 0); cyc();
    chk("p6_pre_update_en", 64'(update_en), 64'(1));
    #2 do_reset();
    chk("p6_post_count", 64'(count), 64'(0));
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rtg;
      rtg = (q.size() != 0 && $urandom_range(3) != 0) ? q[0].tg : 32'(($urandom_range(7)) << 4);
      drive($urandom_range(1), 32'($urandom) & 32'hfffc, 1'($urandom_range(1)), 32'(($urandom_range(7)) << 4),
            $urandom_range(9) < 4, 1'($urandom_range(1)), rtg, $urandom_range(19) == 0);
      if (q.size() != 0 && $urandom_range(2) != 0) resolve_taken = q[0].pt;
      cyc();
      if (i % 700 == 699) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
